reaction_game_ctrl: RTL

- Sequencer for the reaction-timer datapath.
- Waits a pseudo-random delay, lights the LED, and counts milliseconds in 4-digit BCD until the player presses the button.
- Latches the result for the 7-segment decoders and flags false starts and timeouts.
- Sits between the synchronized `ui_in[0]` pin and the segment decoders/LED inside the top-level wrapper.

---
 rtl/reaction_pkg.sv | 30 +++
 rtl/reaction_game_ctrl_if.sv | 36 +++
 rtl/bcd_counter4.sv | 56 +++++
 rtl/reaction_game_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction-timer sequencer: FSM state encoding,
// the BCD saturation value and the LFSR feedback taps.
// No ports (package).
// -----------------------------------------------------------------------------
package reaction_pkg;

  // State encoding is visible on the debug port, so the values are fixed.
  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DELAY   = 3'd1;
  localparam logic [2:0] ST_GO      = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_FOUL    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  // Largest value the 4-digit BCD millisecond counter can show.
  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One shift of the maximal-length LFSR; a non-zero value never maps to 0.
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// reaction_game_ctrl_if
// Groups the player button and the display/LED outputs of the reaction-timer
// sequencer.
//   btn          : raw asynchronous player button (into the sequencer)
//   led          : "GO" lamp
//   result_bcd   : four BCD digits, [15:12] = thousands of ms
//   result_valid : result is final (DONE or TIMEOUT)
//   foul         : false start flagged
//   timeout      : player never pressed
//   state        : current FSM state, for debug
// Modports: slave = the sequencer, master = whatever drives the button and
// consumes the outputs.
// -----------------------------------------------------------------------------
interface reaction_game_ctrl_if;
  import reaction_pkg::*;

  logic        btn;
  logic        led;
  logic [15:0] result_bcd;
  logic        result_valid;
  logic        foul;
  logic        timeout;
  state_t      state;

  modport slave (
    input  btn,
    output led, result_bcd, result_valid, foul, timeout, state
  );

  modport master (
    output btn,
    input  led, result_bcd, result_valid, foul, timeout, state
  );

endinterface

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD incrementer with synchronous clear and enable. The count
// saturates at 9999 instead of wrapping; o_atMax tells the owner it is there.
//   clk     : system clock
//   rst     : synchronous active-high reset, clears the count
//   i_clr   : clear the count to 0000
//   i_en    : advance by one (ignored at 9999)
//   o_count : current count, [15:12] = most significant digit
//   o_atMax : count equals 9999
// -----------------------------------------------------------------------------
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_count,
  output logic        o_atMax
);

  logic [15:0] r_count;
  logic [15:0] w_next;
  logic        w_carry;

  // Ripple a +1 through the digits: a digit at 9 rolls to 0 and passes the
  // carry on, the first digit below 9 absorbs it.
  always_comb begin
    w_next  = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_count[i*4 +: 4] == 4'd9) begin
          w_next[i*4 +: 4] = 4'd0;
        end else begin
          w_next[i*4 +: 4] = r_count[i*4 +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  assign o_atMax = (r_count == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= 16'h0000;
    end else if (i_en && !o_atMax) begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/reaction_game_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_game_ctrl
// Reaction-timer sequencer: waits a pseudo-random delay, lights the GO lamp,
// counts milliseconds in BCD until the button is pressed, then latches the
// result. Early presses are flagged as fouls, a count that hits 9999 ms ends
// in timeout.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : reaction_game_ctrl_if.slave (btn in; led, result_bcd, result_valid,
//         foul, timeout, state out)
// Parameters: TICK_DIV clocks per ms, MIN_DELAY_MS fixed delay part,
// RAND_BITS width of the random delay addend, LFSR_SEED non-zero seed.
// -----------------------------------------------------------------------------
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  reaction_game_ctrl_if.slave bus
);

  logic        r_sync1, r_sync2, r_sync3;
  logic        w_rise;
  logic [15:0] r_lfsr;
  logic [15:0] r_presc;
  logic        w_tick;
  state_t      r_state, w_nextState;
  logic [13:0] r_delayCnt;
  logic [13:0] w_delayLoad;
  logic        w_loadDelay, w_bcdClr, w_bcdEn, w_enterTimer;
  logic        w_atMax;
  logic [15:0] w_count;

  // Button synchronizer plus edge-detect stage. During reset all stages take
  // the current button level, so a button already held when reset releases
  // never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= bus.btn;
      r_sync2 <= bus.btn;
      r_sync3 <= bus.btn;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;

  // Free-running random source; its low bits pick the delay at round start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsrStep(r_lfsr);
    end
  end

  assign w_tick      = (r_presc == 16'(TICK_DIV - 1));
  assign w_delayLoad = 14'(MIN_DELAY_MS) + 14'(r_lfsr[RAND_BITS-1:0]);

  // Next-state logic. A press always beats a tick arriving in the same cycle,
  // both for the last DELAY tick and for a GO tick.
  always_comb begin
    w_nextState = r_state;
    w_loadDelay = 1'b0;
    w_bcdClr    = 1'b0;
    w_bcdEn     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_nextState = ST_DELAY;
          w_loadDelay = 1'b1;
        end
      end
      ST_DELAY: begin
        if (w_rise) begin
          w_nextState = ST_FOUL;
        end else if (w_tick && (r_delayCnt == 14'd1)) begin
          w_nextState = ST_GO;
          w_bcdClr    = 1'b1;
        end
      end
      ST_GO: begin
        if (w_rise) begin
          w_nextState = ST_DONE;
        end else if (w_tick) begin
          if (w_atMax) begin
            w_nextState = ST_TIMEOUT;
          end else begin
            w_bcdEn = 1'b1;
          end
        end
      end
      ST_DONE, ST_FOUL, ST_TIMEOUT: begin
        if (w_rise) begin
          w_nextState = ST_DELAY;
          w_loadDelay = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // The ms grid restarts whenever a timed state is entered so the first
  // tick always lands a full period after entry.
  assign w_enterTimer = (w_nextState != r_state) &&
                        ((w_nextState == ST_DELAY) || (w_nextState == ST_GO));

  always_ff @(posedge clk) begin
    if (rst || w_enterTimer || w_tick) begin
      r_presc <= 16'd0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_delayCnt <= 14'd0;
    end else if (w_loadDelay) begin
      r_delayCnt <= w_delayLoad;
    end else if ((r_state == ST_DELAY) && w_tick && !w_rise) begin
      r_delayCnt <= r_delayCnt - 14'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  bcd_counter4 u_bcd (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_bcdClr),
    .i_en    (w_bcdEn),
    .o_count (w_count),
    .o_atMax (w_atMax)
  );

  // Outputs decode straight from the state register, so they change on the
  // same edge as the state.
  assign bus.led          = (r_state == ST_GO);
  assign bus.result_valid = (r_state == ST_DONE) || (r_state == ST_TIMEOUT);
  assign bus.foul         = (r_state == ST_FOUL);
  assign bus.timeout      = (r_state == ST_TIMEOUT);
  assign bus.state        = r_state;
  assign bus.result_bcd   = w_count;

endmodule
